// File: rtl/h_counter_if.sv
// Horizontal timing bundle from h_counter to the rest of the VGA pipeline.
// Latency: none (wires only).
// Backpressure: none; the timing flags are free-running and never stall.
//
// Signals:
//   h_count    - current pixel column, 0..H_TOTAL-1
//   pixel_tick - one clk cycle high per pixel period
//   enable_v   - one-cycle end-of-line pulse for v_counter
//   hsync      - horizontal sync, active low
//   h_active   - high while h_count is within the visible region
interface h_counter_if;
  logic [9:0] h_count;
  logic       pixel_tick;
  logic       enable_v;
  logic       hsync;
  logic       h_active;

  modport master (
    output h_count,
    output pixel_tick,
    output enable_v,
    output hsync,
    output h_active
  );

  modport slave (
    input h_count,
    input pixel_tick,
    input enable_v,
    input hsync,
    input h_active
  );
endinterface

// File: rtl/h_counter.sv
// Horizontal VGA timing: divides clk to the pixel rate, counts columns, makes hsync/h_active.
// Latency: hsync/h_active change on the same edge as h_count; enable_v coincides with the wrap tick.
// Backpressure: none; free-running, only reset_n stops it.
//
// Ports:
//   clk     - system clock (shared with v_counter)
//   reset_n - synchronous active-low reset
//   tmg     - h_counter_if master: h_count, pixel_tick, enable_v, hsync, h_active
//
// CLK_DIV legal range is 2..16; H_TOTAL must fit in 10 bits.
module h_counter #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  h_counter_if.master tmg
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]    ACTIVE_END = 10'(H_VISIBLE);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_count_q;
  logic [9:0]    h_count_nxt;
  logic          hsync_q;
  logic          h_active_q;
  logic          pixel_tick;
  logic          line_end;

  // Both strobes decode registered state only, so they are glitch-free and
  // read 0 in the cycle after reset (div_cnt is 0 and CLK_DIV >= 2).
  assign pixel_tick = (div_cnt == DIV_LAST);
  assign line_end   = (h_count_q == H_LAST);

  // Explicit wrap at H_TOTAL-1; never relies on 10-bit overflow.
  always_comb begin
    h_count_nxt = h_count_q;
    if (pixel_tick) begin
      h_count_nxt = line_end ? 10'd0 : h_count_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      h_count_q  <= 10'd0;
      hsync_q    <= 1'b1;
      h_active_q <= 1'b1;
    end else begin
      // Wrap explicitly so non-power-of-two dividers keep the right period.
      div_cnt    <= pixel_tick ? '0 : div_cnt + DW'(1);
      h_count_q  <= h_count_nxt;
      // Loaded from the next column so the flags line up with h_count.
      hsync_q    <= !((h_count_nxt >= SYNC_START) && (h_count_nxt < SYNC_END));
      h_active_q <= (h_count_nxt < ACTIVE_END);
    end
  end

  assign tmg.h_count    = h_count_q;
  assign tmg.pixel_tick = pixel_tick;
  assign tmg.enable_v   = pixel_tick && line_end;
  assign tmg.hsync      = hsync_q;
  assign tmg.h_active   = h_active_q;

endmodule
